// File: rtl/ram_bist_pkg.sv
// Shared definitions for the march-test BIST controller: state encoding,
// default geometry/pattern and the per-run operation count.
package ram_bist_pkg;

  localparam int         ADDR_W_DEF  = 6;
  localparam int         DATA_W_DEF  = 8;
  localparam logic [7:0] PATTERN_DEF = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M0    = 3'd1,
    ST_M1    = 3'd2,
    ST_M2    = 3'd3,
    ST_M3    = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  function automatic int op_count(input int addr_w);
    return 6 * (2 ** addr_w);
  endfunction

  localparam int OP_COUNT = op_count(ADDR_W_DEF);

endpackage

// File: rtl/ram_march_bist_if.sv
// RAM-side bus of the BIST controller. rw/addr/din are valid every cycle from the
// posedge that drives them; the RAM acts on the following negedge and dout is stable by the next posedge.
interface ram_march_bist_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output rw, output addr, output din, input dout);
  modport slave  (input rw, input addr, input din, output dout);
endinterface

// File: rtl/ram_bist_checker.sv
// Read-compare pipeline: captures each issued read's address/expected value and checks
// dout one posedge later, keeping a saturating error count and the first failing read.
module ram_bist_checker #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_rd_issue,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_dout,
  output logic [7:0]        o_err_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);

  logic              r_cmp_vld;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [7:0]        r_err_count;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;
  logic              w_mismatch;

  assign w_mismatch = r_cmp_vld && (i_dout != r_cmp_exp);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_vld   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      r_err_count <= 8'h00;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_cmp_vld <= i_rd_issue;
      if (i_rd_issue) begin
        r_cmp_addr <= i_addr;
        r_cmp_exp  <= i_exp;
      end
      if (i_clear) begin
        r_err_count <= 8'h00;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_mismatch) begin
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h01;
        // Only the first failure of a run is recorded.
        if (r_err_count == 8'h00) begin
          r_fail_addr <= r_cmp_addr;
          r_fail_data <= i_dout;
        end
      end
    end
  end

  assign o_err_count = r_err_count;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

endmodule

// File: rtl/ram_march_bist.sv
// March-test BIST controller (w P asc; r P,w ~P asc; r ~P,w P desc; r P asc) for a
// negedge-clocked RAM, with pass/fail status and first-failure capture.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(PATTERN_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  ram_march_bist_if.master  ram,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [7:0]        o_err_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data,
  output state_t            o_state
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_PEN  = ADDR_LAST - ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_rw, w_rw_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_clear, w_rd_issue;
  logic [DATA_W-1:0] w_exp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_rw    <= 1'b0;
      r_din   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
      r_rw    <= w_rw_nxt;
      r_din   <= w_din_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Sequencing: r_state/r_addr/r_phase describe the op currently on the bus.
  // DRAIN is entered together with the final M3 read, so done lands on the
  // edge that compares that read.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = '0;
    w_phase_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_M0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_clear     = 1'b1;
        end
      end
      ST_M0: begin
        if (r_addr == ADDR_LAST) w_state_nxt = ST_M1;
        else                     w_addr_nxt  = r_addr + ADDR_W'(1);
      end
      ST_M1: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
          w_addr_nxt  = r_addr;
        end else if (r_addr == ADDR_LAST) begin
          w_state_nxt = ST_M2;
          w_addr_nxt  = ADDR_LAST;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
        end
      end
      ST_M2: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
          w_addr_nxt  = r_addr;
        end else if (r_addr == '0) begin
          w_state_nxt = ST_M3;
        end else begin
          w_addr_nxt  = r_addr - ADDR_W'(1);
        end
      end
      ST_M3: begin
        if (r_addr == ADDR_PEN) w_state_nxt = ST_DRAIN;
        w_addr_nxt = r_addr + ADDR_W'(1);
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus op decode for the op being issued on this edge; reads drive din=0.
  always_comb begin
    w_rw_nxt   = 1'b0;
    w_din_nxt  = '0;
    w_rd_issue = 1'b0;
    w_exp      = '0;
    case (w_state_nxt)
      ST_M0: begin
        w_rw_nxt  = 1'b1;
        w_din_nxt = PATTERN;
      end
      ST_M1: begin
        if (w_phase_nxt) begin
          w_rw_nxt  = 1'b1;
          w_din_nxt = ~PATTERN;
        end else begin
          w_rd_issue = 1'b1;
          w_exp      = PATTERN;
        end
      end
      ST_M2: begin
        if (w_phase_nxt) begin
          w_rw_nxt  = 1'b1;
          w_din_nxt = PATTERN;
        end else begin
          w_rd_issue = 1'b1;
          w_exp      = ~PATTERN;
        end
      end
      ST_M3, ST_DRAIN: begin
        w_rd_issue = 1'b1;
        w_exp      = PATTERN;
      end
      default: ;
    endcase
  end

  ram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_clear),
    .i_rd_issue  (w_rd_issue),
    .i_exp       (w_exp),
    .i_addr      (w_addr_nxt),
    .i_dout      (ram.dout),
    .o_err_count (o_err_count),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data)
  );

  assign ram.rw   = r_rw;
  assign ram.addr = r_addr;
  assign ram.din  = r_din;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_pass   = r_done && (o_err_count == 8'h00);
  assign o_state  = r_state;

endmodule
